// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button-handling blocks (debouncer users, click
// decoder, stopwatch time base).
//   DEF_PRESCALE     : default clk cycles per 1 ms time-base tick (100 MHz)
//   DEF_CLICK_WINDOW : default number of ms ticks allowed between clicks
//   IDLE/WAIT2/WAIT3 : click-decoder state encoding
// ---------------------------------------------------------------------------
package btn_pkg;

  localparam int DEF_PRESCALE     = 100_000;
  localparam int DEF_CLICK_WINDOW = 250;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] WAIT2_ENC = 2'd1;
  localparam logic [1:0] WAIT3_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = IDLE_ENC,   // no click sequence open
    WAIT2 = WAIT2_ENC,  // one click seen, waiting for a second
    WAIT3 = WAIT3_ENC   // two clicks seen, waiting for a third
  } state_e;

endpackage

// File: rtl/btn_click_decoder_if.sv
// ---------------------------------------------------------------------------
// btn_click_decoder_if
// Groups the click input and the classified-event outputs of the click
// decoder.
//   i_btn    : debounced click pulse (1 clk wide)
//   o_single : 1-clk pulse, single click
//   o_double : 1-clk pulse, double click
//   o_triple : 1-clk pulse, triple click (0 unless triple support is built)
//   o_busy   : a click sequence is open
// Modports:
//   master : the side that supplies clicks and consumes events
//   slave  : the decoder itself
// ---------------------------------------------------------------------------
interface btn_click_decoder_if;

  logic i_btn;
  logic o_single;
  logic o_double;
  logic o_triple;
  logic o_busy;

  modport master (
    output i_btn,
    input  o_single,
    input  o_double,
    input  o_triple,
    input  o_busy
  );

  modport slave (
    input  i_btn,
    output o_single,
    output o_double,
    output o_triple,
    output o_busy
  );

endinterface

// File: rtl/btn_tick_gen.sv
// ---------------------------------------------------------------------------
// btn_tick_gen
// Prescaler producing a one-cycle time-base tick every PRESCALE clk cycles.
// The counter runs 0..PRESCALE-1; o_tick is high while it sits at PRESCALE-1.
// A synchronous clear restarts the count so a new period begins exactly on
// the cycle after the clear.
// Parameters:
//   PRESCALE : clk cycles per tick (>= 2)
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   i_clear : synchronous restart of the period (has priority)
//   o_tick  : one-cycle tick
// ---------------------------------------------------------------------------
module btn_tick_gen
  import btn_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int              CNT_W    = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/btn_click_decoder.sv
// ---------------------------------------------------------------------------
// btn_click_decoder
// Classifies debounced click pulses into single / double (and optionally
// triple) click events. Every accepted click restarts a window of
// W = CLICK_WINDOW * PRESCALE cycles; a click arriving within the window
// extends the sequence, window expiry closes it. Events are registered
// one-clk pulses, delivered the cycle after the deciding edge.
//
// Build option:
//   CLICK_TRIPLE_EN : when defined, a second click opens a further window and
//                     a third click yields o_triple; a double click is then
//                     reported on expiry of that window. When undefined the
//                     second click yields o_double directly and o_triple is 0.
//
// Parameters:
//   PRESCALE     : clk cycles per ms tick (>= 2)
//   CLICK_WINDOW : ms ticks allowed between consecutive clicks (>= 1)
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : btn_click_decoder_if.slave (i_btn in; o_single/o_double/o_triple/
//         o_busy out)
// ---------------------------------------------------------------------------
module btn_click_decoder
  import btn_pkg::*;
#(
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int CLICK_WINDOW = DEF_CLICK_WINDOW
) (
  input  logic                 clk,
  input  logic                 rst,
  btn_click_decoder_if.slave   bus
);

  localparam int               WIN_W    = $clog2(CLICK_WINDOW + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CLICK_WINDOW - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIN_W-1:0] r_win_cnt;
  logic             r_single;
  logic             r_double;
  logic             r_busy;
  logic             w_single_next;
  logic             w_double_next;
  logic             w_ms_tick;
  logic             w_expiry;
  logic             w_clear;

  // Expiry is only meaningful while a sequence is open.
  assign w_expiry = w_ms_tick && (r_win_cnt == WIN_LAST) && (r_state != IDLE);

  // Counters are held at zero while idle and restarted by every click, so the
  // window always starts counting in the cycle right after a click.
  assign w_clear = bus.i_btn || w_expiry || (r_state == IDLE);

  btn_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .o_tick  (w_ms_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_cnt <= '0;
    end else if (w_clear) begin
      r_win_cnt <= '0;
    end else if (w_ms_tick) begin
      r_win_cnt <= r_win_cnt + 1'b1;
    end
  end

`ifdef CLICK_TRIPLE_EN
  logic r_triple;
  logic w_triple_next;
`endif

  // Next-state and event decode. A click is tested before expiry so that a
  // click landing on the last window cycle still joins the sequence.
  always_comb begin
    w_state_next  = r_state;
    w_single_next = 1'b0;
    w_double_next = 1'b0;
`ifdef CLICK_TRIPLE_EN
    w_triple_next = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (bus.i_btn) begin
          w_state_next = WAIT2;
        end
      end
      WAIT2: begin
        if (bus.i_btn) begin
`ifdef CLICK_TRIPLE_EN
          w_state_next = WAIT3;
`else
          w_state_next  = IDLE;
          w_double_next = 1'b1;
`endif
        end else if (w_expiry) begin
          w_state_next  = IDLE;
          w_single_next = 1'b1;
        end
      end
`ifdef CLICK_TRIPLE_EN
      WAIT3: begin
        if (bus.i_btn) begin
          w_state_next  = IDLE;
          w_triple_next = 1'b1;
        end else if (w_expiry) begin
          w_state_next  = IDLE;
          w_double_next = 1'b1;
        end
      end
`endif
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_single <= 1'b0;
      r_double <= 1'b0;
`ifdef CLICK_TRIPLE_EN
      r_triple <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      // Busy tracks the registered state, so it drops together with the
      // event pulse that closes the sequence.
      r_busy   <= (w_state_next != IDLE);
      r_single <= w_single_next;
      r_double <= w_double_next;
`ifdef CLICK_TRIPLE_EN
      r_triple <= w_triple_next;
`endif
    end
  end

  assign bus.o_single = r_single;
  assign bus.o_double = r_double;
  assign bus.o_busy   = r_busy;
`ifdef CLICK_TRIPLE_EN
  assign bus.o_triple = r_triple;
`else
  assign bus.o_triple = 1'b0;
`endif

endmodule

// File: doc/btn_click_decoder.md
Name: btn_click_decoder

Overview:
Consumes the 1-clk rising-edge pulse produced by the button debouncer and classifies button activity into click events: single click or double click, plus triple click when the optional feature is built in. Sits between the debouncer and the stopwatch control unit. Each event is delivered as a one-clk pulse, so the control unit can bind two or three functions to one physical button.

Parameters:
PRESCALE, 100_000, clk cycles per time-base tick (1 ms at 100 MHz); minimum 2.
CLICK_WINDOW, 250, number of time-base ticks allowed between consecutive clicks; minimum 1.

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  asynchronous, active-low reset; block is in reset while rst==0
i_btn  input  1  debounced click pulse, 1 clk wide, may arrive any cycle
o_single  output  1  1-clk pulse: single click classified
o_double  output  1  1-clk pulse: double click classified
o_triple  output  1  1-clk pulse: triple click classified (constant 0 unless CLICK_TRIPLE_EN)
o_busy  output  1  high while a click sequence is open (state != IDLE)

Behaviour:
- Reset (rst==0, async): state=IDLE, prescaler=0, window count=0. o_single, o_double, o_triple and o_busy are all 0.
- Window timing:
  - Prescaler counts 0..PRESCALE-1 and asserts an internal ms_tick when it equals PRESCALE-1.
  - Window counter counts ms_ticks. Expiry = ms_tick while win_cnt==CLICK_WINDOW-1.
  - Both counters are cleared on every accepted click, so each window is exactly W = CLICK_WINDOW*PRESCALE cycles.
- State machine:
  - IDLE: on i_btn -> WAIT2, clear counters.
  - WAIT2: on i_btn -> emit double, go to IDLE. On expiry -> emit single, go to IDLE.
- Timing rule: a click sampled in cycle T opens a window spanning T+1..T+W.
  - A click in any cycle T+1..T+W joins the sequence.
  - Expiry occurs in cycle T+W.
  - Each event output pulses in the cycle after the deciding edge (registered outputs, latency 1).
- Simultaneous click and expiry in the same cycle: the click wins and joins the sequence.
- Event pulse and new click in the same cycle: the state is already IDLE, so the click opens a new sequence. No click is ever dropped.
- o_busy is registered with the state: it rises in the cycle after the first click and falls in the same cycle the event pulses.
- At most one event output is high in any cycle.
- Reset mid-sequence: the sequence is discarded and no event is emitted.
- Counter widths: $clog2(PRESCALE) and $clog2(CLICK_WINDOW+1). No wrap is possible, because expiry resets both counters.

Optional Feature:
CLICK_TRIPLE_EN.
- Defined:
  - WAIT2 + i_btn -> WAIT3, clear counters.
  - WAIT3 + i_btn -> emit triple, go to IDLE.
  - WAIT3 expiry -> emit double, go to IDLE.
  - A double click is therefore reported W cycles after its second click.
- Undefined: no WAIT3 state; o_triple is tied to 0.

Decomposition:
- Shared package btn_pkg holds:
  - state encoding localparams: IDLE, WAIT2, WAIT3;
  - the default PRESCALE and CLICK_WINDOW values, shared with btn_debounce users.
- One natural sub-module, btn_tick_gen: a prescaler with a synchronous clear input that produces ms_tick. It is reusable by the stopwatch time base.

Test Plan (PRESCALE=10, CLICK_WINDOW=5, so W=50):
- Reset: hold rst=0 for 5 clk with i_btn pulsing -> all outputs 0, o_busy 0. Release -> no spurious event within 200 clk.
- Single click: one i_btn pulse at T -> o_busy=1 from T+1. o_single=1 only at T+51. o_busy=0 at T+51.
- Double at edges:
  - Second pulse at T+1 -> o_double at T+2.
  - Second pulse at T+50 (same cycle as expiry) -> o_double at T+51, no o_single.
- Late second click: pulse at T+51 -> o_single at T+51, a new sequence opens, and a further single follows at T+102.
- Reset mid-sequence: pulse at T, rst=0 at T+20 for 3 clk -> no event output, o_busy=0 immediately (async).
- CLICK_TRIPLE_EN build: pulses at T, T+10, T+20 -> o_triple at T+21. Pulses at T, T+10 only -> o_double at T+61.
